ahb_rsa_word_mover: RTL and testbench
=====================================

AHB_RSA_WORD_MOVER -- requirements
Module: ahb_rsa_word_mover

Interface
REQ-001 SHALL provide parameter P_DST_INC, default 1, meaning: 1 increments the destination address by 4 per word, 0 holds it fixed (FIFO-style target).
REQ-002 SHALL provide parameter P_LEN_W, default 8, meaning: width of the word-count input.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: HCLK in 1 (all state on rising edge); HRESETn in 1 (active-low async reset).
REQ-004 Control ports SHALL be: start in 1, go pulse; src_addr in 32, source byte address; dst_addr in 32, destination byte address; num_words in P_LEN_W, word count.
REQ-005 Status ports SHALL be: busy out 1, transfer active; done out 1, one-cycle completion pulse; error out 1, sticky bus-error flag; irq out 1, level (done seen or error) until next start.
REQ-006 AHB master ports SHALL be: mHBUSREQ out 1; mHGRANT in 1; mHADDR out 32; mHTRANS out 2; mHWRITE out 1; mHSIZE out 3; mHBURST out 3; mHPROT out 4; mHLOCK out 1; mHWDATA out 32; mHRDATA in 32; mHRESP in 2; mHREADY in 1.

Function
REQ-007 Block SHALL copy num_words 32-bit words from src_addr to the ahb_rsa2048 slave window at dst_addr using single, non-pipelined AHB transfers (read one word, then write it).
REQ-008 Fixed outputs SHALL be: mHSIZE=3'b010, mHBURST=3'b000 (SINGLE), mHPROT=4'b0011, mHLOCK=0.
REQ-009 mHADDR[1:0] SHALL always be 2'b00; src_addr[1:0] and dst_addr[1:0] are ignored.
REQ-010 FSM states SHALL be IDLE, REQ, RD_A, RD_D, WR_A, WR_D, DONE, ERR.
REQ-011 IDLE: start=1 latches src, dst, count; count=0 -> DONE, else -> REQ; busy=1 from the cycle after start.
REQ-012 REQ: mHBUSREQ=1, mHTRANS=IDLE; -> RD_A when mHGRANT=1 and mHREADY=1.
REQ-013 RD_A: mHTRANS=NONSEQ, mHWRITE=0, mHADDR=src; -> RD_D on the edge where mHREADY=1.
REQ-014 RD_D: mHTRANS=IDLE; on mHREADY=1 with mHRESP=OKAY, capture mHRDATA into a 32-bit buffer, -> WR_A.
REQ-015 WR_A: mHTRANS=NONSEQ, mHWRITE=1, mHADDR=dst; -> WR_D on mHREADY=1.
REQ-016 WR_D: mHWDATA=buffer, mHTRANS=IDLE; on mHREADY=1 with OKAY: src+=4, dst+=4 if P_DST_INC=1, count-=1; count reaching 0 -> DONE, else -> RD_A if mHGRANT=1, else REQ.
REQ-017 Address increments SHALL wrap modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-018 mHBUSREQ SHALL be 1 in REQ through WR_D, and 0 in IDLE, DONE and ERR.
REQ-019 mHRESP=ERROR in RD_D or WR_D (either cycle of the two-cycle response) SHALL move the FSM to ERR, set error=1 and abort remaining words; mHTRANS SHALL be IDLE on the following cycle.
REQ-020 DONE: done=1 for exactly one cycle, busy=0 on the next cycle, -> IDLE. ERR: done=1 for one cycle, -> IDLE.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 mHWDATA SHALL hold the buffer outside WR_D; no X is ever driven.
REQ-023 With a zero-wait slave and continuous grant, start-to-done latency SHALL be 2+4*N cycles; each slave wait state adds one cycle.
REQ-024 start in IDLE SHALL clear error and irq.

Reset
REQ-025 On HRESETn=0 the block SHALL asynchronously enter IDLE with mHTRANS=IDLE, mHBUSREQ=0, mHADDR=0, mHWRITE=0, mHWDATA=0, busy=0, done=0, error=0, irq=0, and counters and buffer cleared.
REQ-026 Reset asserted mid-transfer SHALL abort immediately; no further bus activity follows deassertion until a new start.

Verification
REQ-027 Zero-wait memory holds 0x11111111..0x44444444 at 0x00000100; src=0x100, dst=0x78000000, N=4 -> four reads and four writes in order, same data, done at cycle 18, irq=1.
REQ-028 N=0 -> no NONSEQ on the bus, done pulses one cycle after start, error=0.
REQ-029 Slave inserts 2 wait states on every access, N=2 -> data intact, latency 2+8+8=18 cycles.
REQ-030 Slave returns ERROR on the 2nd write, N=3 -> error=1, exactly 2 reads and 2 writes issued, done pulses, 3rd word never read.
REQ-031 src=0xFFFFFFFC, P_DST_INC=0, N=2 -> second read at 0x00000000, both writes to the same dst.
REQ-032 HRESETn asserted in WR_A, then released -> all outputs at reset values, bus IDLE; a subsequent start completes normally.

Source files
------------

// File: rtl/ahb_rsa_word_mover.sv
// ahb_rsa_word_mover: copies N words from an AHB source into the rsa2048 slave window with single non-pipelined transfers
module ahb_rsa_word_mover #(
  parameter int P_DST_INC = 1,
  parameter int P_LEN_W = 8
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               start,
  input  logic [31:0]        src_addr,
  input  logic [31:0]        dst_addr,
  input  logic [P_LEN_W-1:0] num_words,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               irq,
  output logic               mHBUSREQ,
  input  logic               mHGRANT,
  output logic [31:0]        mHADDR,
  output logic [1:0]         mHTRANS,
  output logic               mHWRITE,
  output logic [2:0]         mHSIZE,
  output logic [2:0]         mHBURST,
  output logic [3:0]         mHPROT,
  output logic               mHLOCK,
  output logic [31:0]        mHWDATA,
  input  logic [31:0]        mHRDATA,
  input  logic [1:0]         mHRESP,
  input  logic               mHREADY
);
  typedef enum logic [2:0] {IDLE, REQ, RD_A, RD_D, WR_A, WR_D, DONE, ERR} state_t;
  state_t state, state_n;
  logic [31:0] src_q, dst_q, buf_q;
  logic [P_LEN_W-1:0] cnt;
  logic ok_beat, bus_err;
  assign ok_beat = mHREADY && mHRESP == 2'b00;
  assign bus_err = mHRESP == 2'b01;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = (num_words == '0) ? DONE : REQ;
      REQ:  if (mHGRANT && mHREADY) state_n = RD_A;
      RD_A: if (mHREADY) state_n = RD_D;
      RD_D: state_n = bus_err ? ERR : ok_beat ? WR_A : RD_D;
      WR_A: if (mHREADY) state_n = WR_D;
      WR_D: state_n = bus_err ? ERR : !ok_beat ? WR_D : (cnt == P_LEN_W'(1)) ? DONE : mHGRANT ? RD_A : REQ;
      default: state_n = IDLE;
    endcase
  end
  assign busy     = state != IDLE;
  assign done     = state == DONE || state == ERR;
  assign mHBUSREQ = state inside {REQ, RD_A, RD_D, WR_A, WR_D};
  assign mHTRANS  = (state == RD_A || state == WR_A) ? 2'b10 : 2'b00;
  assign mHWRITE  = state == WR_A;
  assign mHADDR   = (state == RD_A) ? src_q : (state == WR_A) ? dst_q : '0;
  assign mHWDATA  = buf_q;
  assign mHSIZE   = 3'b010;
  assign mHBURST  = 3'b000;
  assign mHPROT   = 4'b0011;
  assign mHLOCK   = 1'b0;
  // addresses are stored word-aligned so increments wrap cleanly at 2^32
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      buf_q <= '0;
      cnt   <= '0;
      error <= 1'b0;
      irq   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        src_q <= src_addr & ~32'h3;
        dst_q <= dst_addr & ~32'h3;
        cnt   <= num_words;
        error <= 1'b0;
        irq   <= 1'b0;
      end
      if (state == RD_D && ok_beat) buf_q <= mHRDATA;
      if (state == WR_D && ok_beat) begin
        src_q <= src_q + 32'd4;
        if (P_DST_INC != 0) dst_q <= dst_q + 32'd4;
        cnt <= cnt - P_LEN_W'(1);
      end
      if (state_n == ERR) error <= 1'b1;
      if (state_n == DONE || state_n == ERR) irq <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ahb_rsa_word_mover.sv
// tb_ahb_rsa_word_mover: directed bench with a wait/error-capable AHB slave model and two DUT instances
module tb_ahb_rsa_word_mover;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;
  logic start = 1'b0, sel = 1'b0, clr = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [7:0] num_words = '0;
  int waits = 0, err_wr = 0;
  logic start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;
  logic [1:0] busy_v, done_v, error_v, irq_v, busreq_v, hwrite_v, hlock_v;
  logic [31:0] haddr_v [2];
  logic [31:0] hwdata_v [2];
  logic [1:0] htrans_v [2];
  logic [2:0] hsize_v [2];
  logic [2:0] hburst_v [2];
  logic [3:0] hprot_v [2];
  logic s_ready;
  logic [1:0] s_resp;
  logic [31:0] s_rdata;
  ahb_rsa_word_mover #(.P_DST_INC(1), .P_LEN_W(8)) u_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start_a), .src_addr(src_addr), .dst_addr(dst_addr),
    .num_words(num_words), .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0]), .irq(irq_v[0]),
    .mHBUSREQ(busreq_v[0]), .mHGRANT(1'b1), .mHADDR(haddr_v[0]), .mHTRANS(htrans_v[0]),
    .mHWRITE(hwrite_v[0]), .mHSIZE(hsize_v[0]), .mHBURST(hburst_v[0]), .mHPROT(hprot_v[0]),
    .mHLOCK(hlock_v[0]), .mHWDATA(hwdata_v[0]), .mHRDATA(s_rdata), .mHRESP(s_resp), .mHREADY(s_ready));
  ahb_rsa_word_mover #(.P_DST_INC(0), .P_LEN_W(8)) u_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start_b), .src_addr(src_addr), .dst_addr(dst_addr),
    .num_words(num_words), .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1]), .irq(irq_v[1]),
    .mHBUSREQ(busreq_v[1]), .mHGRANT(1'b1), .mHADDR(haddr_v[1]), .mHTRANS(htrans_v[1]),
    .mHWRITE(hwrite_v[1]), .mHSIZE(hsize_v[1]), .mHBURST(hburst_v[1]), .mHPROT(hprot_v[1]),
    .mHLOCK(hlock_v[1]), .mHWDATA(hwdata_v[1]), .mHRDATA(s_rdata), .mHRESP(s_resp), .mHREADY(s_ready));
  logic busy, done, error, irq, busreq, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0] htrans;
  assign busy   = busy_v[sel];
  assign done   = done_v[sel];
  assign error  = error_v[sel];
  assign irq    = irq_v[sel];
  assign busreq = busreq_v[sel];
  assign hwrite = hwrite_v[sel];
  assign haddr  = haddr_v[sel];
  assign hwdata = hwdata_v[sel];
  assign htrans = htrans_v[sel];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100: return 32'h11111111;
      32'h104: return 32'h22222222;
      32'h108: return 32'h33333333;
      32'h10C: return 32'h44444444;
      32'hFFFFFFFC: return 32'hAAAA5555;
      32'h0: return 32'h0BADF00D;
      default: return 32'hDEAD0000 | a[15:0];
    endcase
  endfunction
  logic dp, dpw;
  logic [31:0] dpa;
  int wcnt, eph, rd_iss, wr_iss;
  logic [31:0] rd_log[$], wa_log[$], wd_log[$];
  assign s_ready = !dp || eph == 2 || (eph == 0 && wcnt == 0);
  assign s_resp  = (eph != 0) ? 2'b01 : 2'b00;
  assign s_rdata = (dp && !dpw && eph == 0 && wcnt == 0) ? mem_rd(dpa) : 32'h0;
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp <= 1'b0;
      dpw <= 1'b0;
      dpa <= '0;
      eph <= 0;
      wcnt <= 0;
    end else begin
      if (clr) begin
        rd_iss <= 0;
        wr_iss <= 0;
        rd_log.delete();
        wa_log.delete();
        wd_log.delete();
      end
      if (dp) begin
        if (eph == 1) eph <= 2;
        else if (eph == 2) begin
          dp <= 1'b0;
          eph <= 0;
        end else if (wcnt != 0) wcnt <= wcnt - 1;
        else begin
          dp <= 1'b0;
          if (dpw) begin
            wa_log.push_back(dpa);
            wd_log.push_back(hwdata);
          end
        end
      end
      if (htrans == 2'b10 && s_ready) begin
        dp <= 1'b1;
        dpa <= haddr;
        dpw <= hwrite;
        wcnt <= waits;
        if (hwrite) begin
          wr_iss <= wr_iss + 1;
          if (wr_iss + 1 == err_wr) eph <= 1;
        end else begin
          rd_iss <= rd_iss + 1;
          rd_log.push_back(haddr);
        end
      end
    end
  end
  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic s, input logic [31:0] sa, input logic [31:0] da, input logic [7:0] n,
                     input int w, input int ew, input bit poke, output int cyc);
    @(negedge HCLK);
    sel = s;
    waits = w;
    err_wr = ew;
    clr = 1'b1;
    @(negedge HCLK);
    clr = 1'b0;
    src_addr = sa;
    dst_addr = da;
    num_words = n;
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", busy, 1'b1);
    chk("error_cleared", error, 1'b0);
    if (n != 0) chk("irq_cleared", irq, 1'b0);
    while (!done && cyc < 300) begin
      if (poke && cyc == 5) begin
        src_addr = 32'h200;
        num_words = 8'd1;
        start = 1'b1;
      end
      @(negedge HCLK);
      start = 1'b0;
      cyc++;
    end
    chk("done_seen", done, 1'b1);
    @(negedge HCLK);
    chk("done_one_cycle", done, 1'b0);
    chk("busy_dropped", busy, 1'b0);
  endtask
  int cyc, snap;
  initial begin
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_busreq", busreq, 1'b0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("fixed_ctrl", {hsize_v[0], hburst_v[0], hprot_v[0], hlock_v[0]}, {3'b010, 3'b000, 4'b0011, 1'b0});
    @(negedge HCLK);
    HRESETn = 1'b1;
    run(1'b0, 32'h100, 32'h78000000, 8'd4, 0, 0, 1'b1, cyc);
    chk("n4_latency", cyc, 18);
    chk("n4_reads", rd_log.size(), 4);
    chk("n4_writes", wa_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("n4_rd_addr", rd_log[i], 32'h100 + 4 * i);
      chk("n4_wr_addr", wa_log[i], 32'h78000000 + 4 * i);
      chk("n4_wr_data", wd_log[i], 32'h11111111 * (i + 1));
    end
    chk("n4_irq", irq, 1'b1);
    chk("n4_error", error, 1'b0);
    run(1'b0, 32'h100, 32'h78000000, 8'd0, 0, 0, 1'b0, cyc);
    chk("n0_latency", cyc, 1);
    chk("n0_no_nonseq", rd_iss + wr_iss, 0);
    chk("n0_error", error, 1'b0);
    chk("n0_irq", irq, 1'b1);
    run(1'b0, 32'h103, 32'h78000002, 8'd2, 2, 0, 1'b0, cyc);
    chk("wait_latency", cyc, 18);
    chk("wait_writes", wd_log.size(), 2);
    for (int i = 0; i < 2; i++) begin
      chk("wait_rd_addr", rd_log[i], 32'h100 + 4 * i);
      chk("wait_wr_addr", wa_log[i], 32'h78000000 + 4 * i);
      chk("wait_wr_data", wd_log[i], 32'h11111111 * (i + 1));
    end
    run(1'b0, 32'h100, 32'h78000000, 8'd3, 0, 2, 1'b0, cyc);
    chk("err_flag", error, 1'b1);
    chk("err_irq", irq, 1'b1);
    chk("err_reads", rd_iss, 2);
    chk("err_writes", wr_iss, 2);
    chk("err_good_writes", wd_log.size(), 1);
    chk("err_idle_bus", htrans, 2'b00);
    run(1'b1, 32'hFFFFFFFC, 32'h78000010, 8'd2, 0, 0, 1'b0, cyc);
    chk("wrap_rd0", rd_log[0], 32'hFFFFFFFC);
    chk("wrap_rd1", rd_log[1], 32'h0);
    chk("wrap_wr0", wa_log[0], 32'h78000010);
    chk("wrap_wr1", wa_log[1], 32'h78000010);
    chk("wrap_d0", wd_log[0], 32'hAAAA5555);
    chk("wrap_d1", wd_log[1], 32'h0BADF00D);
    @(negedge HCLK);
    sel = 1'b0;
    num_words = 8'd4;
    src_addr = 32'h100;
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    cyc = 0;
    while (!(htrans == 2'b10 && hwrite) && cyc < 50) begin
      @(negedge HCLK);
      cyc++;
    end
    chk("reached_wr_a", {htrans, hwrite}, 3'b101);
    #1 HRESETn = 1'b0;
    #1;
    chk("mid_rst_htrans", htrans, 2'b00);
    chk("mid_rst_busreq", busreq, 1'b0);
    chk("mid_rst_haddr", haddr, 32'h0);
    chk("mid_rst_hwrite", hwrite, 1'b0);
    chk("mid_rst_hwdata", hwdata, 32'h0);
    chk("mid_rst_status", {busy, done, error, irq}, 4'b0000);
    @(negedge HCLK);
    HRESETn = 1'b1;
    snap = rd_iss + wr_iss;
    for (int i = 0; i < 5; i++) @(negedge HCLK);
    chk("post_rst_quiet", rd_iss + wr_iss, snap);
    chk("post_rst_busreq", busreq, 1'b0);
    run(1'b0, 32'h10C, 32'h78000020, 8'd1, 0, 0, 1'b0, cyc);
    chk("post_rst_latency", cyc, 6);
    chk("post_rst_data", wd_log[0], 32'h44444444);
    chk("post_rst_addr", wa_log[0], 32'h78000020);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
